// File: rtl/d16_pkg.sv
// d16_pkg: definitions shared across the d16 codebase slice.
//   - interrupt controller register word offsets
//   - interrupt controller state encoding
//   - interrupt vector rule (vector = code << 1)
//   - the core's INT opcode
package d16_pkg;

    // Word offsets from the controller's BASE_ADDR.
    localparam logic [1:0] INTC_PENDING = 2'd0;
    localparam logic [1:0] INTC_MASK    = 2'd1;
    localparam logic [1:0] INTC_ACTIVE  = 2'd2;
    localparam logic [1:0] INTC_EOI     = 2'd3;

    // Opcode the core injects when it takes an interrupt.
    localparam logic [15:0] D16_OP_INT = 16'h8B90;

    typedef enum logic {
        INTC_IDLE   = 1'b0,
        INTC_ASSERT = 1'b1
    } intc_state_e;

    // Vector address the core jumps to for a given interrupt code.
    function automatic logic [15:0] intc_vector(input logic [2:0] code);
        return {12'd0, code, 1'b0};
    endfunction

endpackage

// File: rtl/d16_intc_if.sv
// d16_intc_if: the core's Wishbone-style data bus as seen by the interrupt
// controller.
//   i_wb_addr  16  word address from the core
//   i_wb_cyc    1  bus cycle
//   i_wb_we     1  write strobe
//   i_wb_dat   16  write data from the core
//   o_wb_dat   16  read data from the peripheral (0 when not selected)
//   o_wb_sel    1  address hit, feeds the system read-data mux
// master = core side, slave = peripheral side.
interface d16_intc_if;
    logic [15:0] i_wb_addr;
    logic        i_wb_cyc;
    logic        i_wb_we;
    logic [15:0] i_wb_dat;
    logic [15:0] o_wb_dat;
    logic        o_wb_sel;

    modport master (
        output i_wb_addr, i_wb_cyc, i_wb_we, i_wb_dat,
        input  o_wb_dat, o_wb_sel
    );

    modport slave (
        input  i_wb_addr, i_wb_cyc, i_wb_we, i_wb_dat,
        output o_wb_dat, o_wb_sel
    );
endinterface

// File: rtl/d16_intc_prio.sv
// d16_intc_prio: 7-to-3 priority encoder, highest index wins.
//   i_req    7  request vector, bit k maps to code k+1
//   o_code   3  k+1 of the highest set bit, 0 if none
//   o_valid  1  any request set
module d16_intc_prio (
    input  logic [6:0] i_req,
    output logic [2:0] o_code,
    output logic       o_valid
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        o_code = 3'd0;
        // Ascending scan: the last (highest) set bit overwrites lower ones.
        for (int k = 0; k < 7; k++) begin
            if (i_req[k]) o_code = 3'(k + 1);
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/d16_intc.sv
// d16_intc: interrupt controller in front of the d16 core's i_int[2:0].
// Latches rising edges of seven sources as pending, masks and prioritises
// them, and holds one code on o_int until software writes EOI. The code
// always drops to 0 for at least one cycle between services so the core's
// 0 -> nonzero edge detector fires once per interrupt.
//   i_clk     1   clock, rising edge
//   i_reset   1   synchronous, active-high reset
//   i_irq     7   sources, bit k maps to code k+1
//   wb        -   register bus (slave side): PENDING, MASK, ACTIVE, EOI
//   o_int     3   code to the core, 0 = none
module d16_intc
    import d16_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFF10
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [6:0]   i_irq,
    d16_intc_if.slave    wb,
    output logic [2:0]   o_int
);

    intc_state_e state_q, state_d;
    logic [6:0]  pending_q, pending_d;
    logic [6:0]  mask_q, mask_d;
    logic [6:0]  prev_irq_q;
    logic [2:0]  active_q, active_d;

    logic [15:0] offset;
    logic        hit;
    logic        wr;
    logic [6:0]  rise;
    logic [6:0]  grant;
    logic [2:0]  prio_code;
    logic        prio_valid;

    // Subtract-and-compare so BASE_ADDR need not be 4-word aligned.
    assign offset = wb.i_wb_addr - BASE_ADDR;
    assign hit    = (offset[15:2] == 14'd0);
    assign wr     = wb.i_wb_cyc & wb.i_wb_we & hit;
    assign rise   = i_irq & ~prev_irq_q;

    d16_intc_prio u_prio (
        .i_req   (pending_q & mask_q),
        .o_code  (prio_code),
        .o_valid (prio_valid)
    );

    // One-hot of the winning source, used to retire its pending bit.
    assign grant = prio_valid ? (7'b1 << (prio_code - 3'd1)) : 7'd0;

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        mask_d    = mask_q;
        pending_d = pending_q;

        if (wr && offset[1:0] == INTC_MASK) mask_d = wb.i_wb_dat[6:0];
        if (wr && offset[1:0] == INTC_PENDING) pending_d = pending_d & ~wb.i_wb_dat[6:0];

        unique case (state_q)
            INTC_IDLE: begin
                // Arbitrates on mask_q, so a same-cycle MASK write only
                // counts from the next cycle.
                if (prio_valid) begin
                    state_d   = INTC_ASSERT;
                    active_d  = prio_code;
                    pending_d = pending_d & ~grant;
                end
            end
            INTC_ASSERT: begin
                if (wr && offset[1:0] == INTC_EOI) begin
                    state_d  = INTC_IDLE;
                    active_d = 3'd0;
                end
            end
        endcase

        // Applied last: a new edge beats both W1C and the service clear.
        pending_d = pending_d | rise;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= INTC_IDLE;
            pending_q  <= 7'd0;
            mask_q     <= 7'd0;
            active_q   <= 3'd0;
            // Track the sources during reset so a line already high at
            // release does not look like a new edge.
            prev_irq_q <= i_irq;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            active_q   <= active_d;
            prev_irq_q <= i_irq;
        end
    end

    assign o_int = (state_q == INTC_ASSERT) ? active_q : 3'd0;

    always_comb begin
        wb.o_wb_dat = 16'd0;
        if (hit) begin
            unique case (offset[1:0])
                INTC_PENDING: wb.o_wb_dat = {9'd0, pending_q};
                INTC_MASK:    wb.o_wb_dat = {9'd0, mask_q};
                INTC_ACTIVE:  wb.o_wb_dat = {(state_q == INTC_ASSERT), 12'd0, active_q};
                INTC_EOI:     wb.o_wb_dat = 16'd0;
            endcase
        end
    end

    assign wb.o_wb_sel = hit;

endmodule

// File: tb/tb_d16_intc.sv
// tb_d16_intc: directed test of d16_intc with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_d16_intc;
    import d16_pkg::*;

    localparam logic [15:0] BASE = 16'hFF10;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [6:0] i_irq;
    logic [2:0] o_int;

    int n_checks = 0;
    int n_pass   = 0;

    d16_intc_if wb ();

    d16_intc #(.BASE_ADDR(BASE)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_irq   (i_irq),
        .wb      (wb.slave),
        .o_int   (o_int)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic bus_rd(input logic [1:0] off, output logic [15:0] data);
        wb.i_wb_addr = BASE + 16'(off);
        wb.i_wb_cyc  = 1'b1;
        wb.i_wb_we   = 1'b0;
        #1;
        data = wb.o_wb_dat;
        wb.i_wb_cyc = 1'b0;
    endtask

    // Write is sampled at the next rising edge; returns 1 unit after it.
    task automatic bus_wr(input logic [1:0] off, input logic [15:0] data);
        wb.i_wb_addr = BASE + 16'(off);
        wb.i_wb_cyc  = 1'b1;
        wb.i_wb_we   = 1'b1;
        wb.i_wb_dat  = data;
        tick();
        wb.i_wb_cyc = 1'b0;
        wb.i_wb_we  = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] off, input logic [15:0] exp);
        logic [15:0] d;
        bus_rd(off, d);
        check(tag, d, exp);
    endtask

    initial begin
        logic [15:0] d;
        i_reset      = 1'b1;
        i_irq        = 7'd0;
        wb.i_wb_addr = 16'd0;
        wb.i_wb_cyc  = 1'b0;
        wb.i_wb_we   = 1'b0;
        wb.i_wb_dat  = 16'd0;
        tick();
        tick();
        i_reset = 1'b0;

        // Reset state
        check("rst_int", 16'(o_int), 16'd0);
        check_reg("rst_pending", INTC_PENDING, 16'd0);
        check_reg("rst_mask", INTC_MASK, 16'd0);
        check_reg("rst_active", INTC_ACTIVE, 16'd0);

        // Address decode
        wb.i_wb_addr = BASE + 16'd4;
        #1;
        check("unsel_sel", 16'(wb.o_wb_sel), 16'd0);
        check("unsel_dat", wb.o_wb_dat, 16'd0);
        wb.i_wb_addr = BASE;
        #1;
        check("sel_hit", 16'(wb.o_wb_sel), 16'd1);

        // Single source, 1-cycle pulse
        bus_wr(INTC_MASK, 16'h0001);
        i_irq = 7'h01;
        tick();
        i_irq = 7'h00;
        check("t1_int_edge_t", 16'(o_int), 16'd0);
        tick();
        check("t1_int", 16'(o_int), 16'd1);
        check_reg("t1_active", INTC_ACTIVE, 16'h8001);
        check_reg("t1_pending", INTC_PENDING, 16'd0);
        check_reg("t1_eoi_read", INTC_EOI, 16'd0);
        bus_wr(INTC_EOI, 16'h0000);
        check("t1_int_eoi", 16'(o_int), 16'd0);
        check_reg("t1_active_eoi", INTC_ACTIVE, 16'h0000);

        // Two sources together: priority, then gap, then the lower one
        bus_wr(INTC_MASK, 16'h007F);
        i_irq = 7'b0100010;
        tick();
        i_irq = 7'h00;
        tick();
        check("t2_int_first", 16'(o_int), 16'd6);
        check_reg("t2_pending", INTC_PENDING, 16'h0002);
        // Mask change while asserted must not disturb the active code
        bus_wr(INTC_MASK, 16'h0002);
        check("t2_int_maskchg", 16'(o_int), 16'd6);
        bus_wr(INTC_EOI, 16'h0000);
        check("t2_int_gap", 16'(o_int), 16'd0);
        tick();
        check("t2_int_second", 16'(o_int), 16'd2);
        bus_wr(INTC_EOI, 16'h0000);
        check("t2_int_eoi2", 16'(o_int), 16'd0);
        // EOI in IDLE is ignored
        bus_wr(INTC_EOI, 16'h0000);
        check("t2_int_idle_eoi", 16'(o_int), 16'd0);
        tick();
        check("t2_int_stays0", 16'(o_int), 16'd0);

        // Masked source stays pending; same-cycle MASK write lags a cycle
        bus_wr(INTC_MASK, 16'h0000);
        i_irq = 7'h08;
        tick();
        i_irq = 7'h00;
        tick();
        check_reg("t3_pending", INTC_PENDING, 16'h0008);
        check("t3_int_masked", 16'(o_int), 16'd0);
        bus_wr(INTC_MASK, 16'h0008);
        check("t3_int_mask_lag", 16'(o_int), 16'd0);
        tick();
        check("t3_int", 16'(o_int), 16'd4);
        // Write to ACTIVE has no effect
        bus_wr(INTC_ACTIVE, 16'hFFFF);
        check_reg("t3_active_ro", INTC_ACTIVE, 16'h8004);
        bus_wr(INTC_EOI, 16'h0000);
        check("t3_int_eoi", 16'(o_int), 16'd0);

        // W1C racing a rising edge: set wins
        bus_wr(INTC_MASK, 16'h0000);
        i_irq = 7'h08;
        bus_wr(INTC_PENDING, 16'h0008);
        i_irq = 7'h00;
        check_reg("t4_set_wins", INTC_PENDING, 16'h0008);
        bus_wr(INTC_PENDING, 16'h0000);
        check_reg("t4_w1c_zero", INTC_PENDING, 16'h0008);
        bus_wr(INTC_PENDING, 16'h0008);
        check_reg("t4_w1c", INTC_PENDING, 16'h0000);

        // Reset during ASSERT, source held high through release
        bus_wr(INTC_MASK, 16'h0040);
        i_irq = 7'h40;
        tick();
        i_irq = 7'h00;
        tick();
        check("t5_int", 16'(o_int), 16'd7);
        i_irq   = 7'h40;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("t5_int_rst", 16'(o_int), 16'd0);
        check_reg("t5_pending_rst", INTC_PENDING, 16'h0000);
        check_reg("t5_mask_rst", INTC_MASK, 16'h0000);
        tick();
        bus_wr(INTC_MASK, 16'h007F);
        tick();
        tick();
        check_reg("t5_held_pending", INTC_PENDING, 16'h0000);
        check("t5_held_int", 16'(o_int), 16'd0);
        i_irq = 7'h00;
        tick();
        check("t5_drop_int", 16'(o_int), 16'd0);

        // Package vector helper sanity against a hand value
        check("vector_7", intc_vector(o_int + 3'd7), 16'h000E);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/d16_intc.md
# d16_intc

Interrupt controller sitting directly upstream of the d16 core's `i_int[2:0]` input. It collects up to seven level-to-edge interrupt sources, latches them as pending, masks and prioritises them, and presents one 3-bit code to the core. The code is held until software signals end-of-interrupt through a memory-mapped register on the core's Wishbone bus. The controller always returns the code to zero between interrupts, so the core's `0 -> nonzero` edge detector fires exactly once per service.

## Interface
- `BASE_ADDR`, default 16'hFF10: word address of register 0; the block decodes `BASE_ADDR .. BASE_ADDR+3`.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_reset`  in  1  reset; synchronous, active-high.
- `i_irq`  in  7  interrupt sources, synchronous to `i_clk`. Bit k maps to code k+1.
- `i_wb_addr`  in  16  core bus address.
- `i_wb_cyc`  in  1  core bus cycle.
- `i_wb_we`  in  1  core write strobe.
- `i_wb_dat`  in  16  write data from core.
- `o_wb_dat`  out  16  read data, combinational from `i_wb_addr`; 0 when not selected.
- `o_wb_sel`  out  1  address hit, for the system read-data mux; combinational.
- `o_int`  out  3  interrupt code to the core; 0 means none.

## Operation
- Registers, at word offset from `BASE_ADDR`:
  - 0 PENDING: bits [6:0], read; write-1-to-clear.
  - 1 MASK: bits [6:0], read/write; 1 enables the source.
  - 2 ACTIVE: read-only; [2:0] current code, [15] busy.
  - 3 EOI: write-only; any write ends the current interrupt. Reads return 0.
- A register write occurs when `i_wb_cyc & i_wb_we & hit`. A read requires no handshake: the core samples `o_wb_dat` in the same cycle. Unused bits read 0.
- Edge detect: `prev_irq` is registered from `i_irq` every cycle. `rise = i_irq & ~prev_irq` sets the matching PENDING bits.
- State machine:
  - IDLE: `o_int = 0`. If `PENDING & MASK != 0`, the highest set bit k wins (bit 6 has highest priority). On the next edge: go to ASSERT, ACTIVE code = k+1, PENDING[k] cleared.
  - ASSERT: `o_int` = ACTIVE code, held steady. An EOI write moves the block to IDLE and clears ACTIVE to 0. Nothing else leaves ASSERT except reset.
- IDLE always lasts at least one cycle, so `o_int` is 0 for at least one cycle between codes. The core requires this for its edge detection.
- Boundary rules:
  - A rising edge and a W1C write on the same PENDING bit in the same cycle: the set wins.
  - A rising edge on the source currently being serviced sets PENDING again; it is re-serviced after EOI.
  - Changing MASK while in ASSERT does not affect the active interrupt.
  - Arbitration in IDLE uses the MASK value from before the edge; a same-cycle MASK write takes effect on the next cycle.
  - EOI in IDLE is ignored.
  - A write to PENDING or ACTIVE with a 0 bit, or a write to ACTIVE at all, has no effect.
  - A source held high produces exactly one pending event.

## Timing
- Reset values: PENDING=0, MASK=0, state IDLE, ACTIVE=0, `o_int`=0. `prev_irq` loads `i_irq` during reset, so a source that is already high at release does not create an event.
- Reset during ASSERT forces `o_int`=0 after the next edge.
- Source latency: `i_irq[k]` is low at edge t-1 and high at edge t. PENDING[k]=1 after edge t. If the block is in IDLE and the source is enabled, `o_int`=k+1 after edge t+1.
- EOI latency: an EOI write sampled at edge e gives `o_int`=0 after edge e. The earliest next nonzero code appears after edge e+1.
- `o_wb_dat` and `o_wb_sel` have zero latency. They are combinational from the address and current register state.

## Structure
- Shared package `d16_pkg`: register offsets (`INTC_PENDING=0`, `INTC_MASK=1`, `INTC_ACTIVE=2`, `INTC_EOI=3`), the IDLE/ASSERT state encoding, the interrupt vector rule (vector = code<<1), and the core's INT opcode 16'h8B90.
- One sub-module: `d16_intc_prio`, a 7-to-3 highest-index priority encoder with a `valid` output. The register file, edge detect and FSM stay in the top module.

## Test plan
- Reset, then MASK=7'h01, then pulse `i_irq[0]` for 1 cycle.
  - Required: `o_int`=1 two edges later; ACTIVE reads 16'h8001; PENDING reads 0.
  - After an EOI write: `o_int`=0 on the next cycle.
- MASK=7'h7F, with `i_irq[1]` and `i_irq[5]` rising together.
  - Required: `o_int`=6 first.
  - After EOI: `o_int`=0 for one cycle, then `o_int`=2.
  - After a second EOI: `o_int` stays 0.
- MASK=0, then `i_irq[3]` rises.
  - Required: PENDING=7'h08 and `o_int`=0.
  - After writing MASK=7'h08: `o_int`=4 two edges later.
- Write PENDING=7'h08 (W1C) in the same cycle that `i_irq[3]` rises.
  - Required: PENDING[3] still 1.
  - Separately, a W1C write of 7'h08 with no edge gives PENDING=0.
- While `o_int`=7, re-pulse `i_irq[6]` and assert `i_reset` for one cycle.
  - Required: `o_int`=0, PENDING=0, MASK=0 after the edge.
  - With `i_irq[6]` held high through reset release: no event is generated.
